// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I funct3 size/sign codes, the FSM state encoding and the
// funct3 legality check used during request decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WR = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   i_funct3  RV32I funct3 of the request
//   i_lane    byte offset within the word (addr[1:0])
//   i_word    word read from data memory
//   i_wdata   right-aligned store data
//   o_load    extracted and sign/zero-extended load result
//   o_merge   memory word with the store byte/half inserted at the lane
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_shift;
  logic [15:0] w_lane_half;

  // Little-endian: lane n occupies bits [8n+7:8n].
  assign w_shift     = {i_lane, 3'b000};
  assign w_lane_half = 16'(i_word >> w_shift);

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_lane_half[7]}}, w_lane_half[7:0]};
      F3_H:    o_load = {{16{w_lane_half[15]}}, w_lane_half};
      F3_BU:   o_load = {24'd0, w_lane_half[7:0]};
      F3_HU:   o_load = {16'd0, w_lane_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_wdata;
    case (i_funct3[1:0])
      2'd0:    o_merge = (i_word & ~(32'h0000_00FF << w_shift)) |
                         ({24'd0, i_wdata[7:0]} << w_shift);
      2'd1:    o_merge = (i_word & ~(32'h0000_FFFF << w_shift)) |
                         ({16'd0, i_wdata[15:0]} << w_shift);
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the core memory stage and a word-addressed
// data memory (async read, sync word write). One request in flight.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store flag and RV32I size/sign code
//   req_addr, req_wdata         byte address, right-aligned store data
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata, rsp_err          extended load data / error flag
//   mem_we, mem_a, mem_wd       data memory write enable, word address, write data
//   mem_rd                      data memory combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_merge;

  logic              w_accept;
  logic              w_misalign;
  logic              w_range;
  logic              w_err;
  logic              w_sub_store;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  // Gating with rst_n keeps a request from writing memory while reset is held.
  assign w_accept    = req_valid && (r_state == ST_IDLE) && rst_n;
  assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign w_range     = (req_addr >= ADDR_W'(MEM_BYTES));
  assign w_sub_store = req_we && (req_funct3 != F3_W);
  assign w_err       = w_misalign || w_range || f3_illegal(req_we, req_funct3);

  always_comb begin
    w_misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    w_misalign = req_addr[0];
      2'd2:    w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  lsu_lane_mux u_lane_mux (
    .i_funct3 (req_funct3),
    .i_lane   (req_addr[1:0]),
    .i_word   (mem_rd),
    .i_wdata  (req_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Accept stage -> registered response / RMW write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_merge <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (!req_we && !w_err) ? w_load : 32'd0;
        r_addr  <= w_word_addr;
        r_merge <= w_merge;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          mem_a = w_word_addr;
          if (w_err) begin
            w_state_nxt = ST_RESP;
          end else if (w_sub_store) begin
            // Sub-word store: this cycle only reads the word to merge into.
            w_state_nxt = ST_RMW_WR;
          end else begin
            w_state_nxt = ST_RESP;
            if (req_we) begin
              mem_we = 1'b1;
              mem_wd = req_wdata;
            end
          end
        end
      end
      ST_RMW_WR: begin
        mem_we      = 1'b1;
        mem_a       = r_addr;
        mem_wd      = r_merge;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
